// File: rtl/alu_issue_ctrl.sv
// Command front-end and 8x8 register file for the combinational 8-bit ALU.
// Runs one command at a time through IDLE -> EXEC -> RESP. In IDLE it reads the
// operands and registers them towards the ALU. In EXEC it captures the ALU
// result and writes it back. In RESP it holds the response until the consumer
// takes it.
module alu_issue_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [2:0] cmd_rd,
    input  logic [2:0] cmd_rs1,
    input  logic [2:0] cmd_rs2,
    input  logic       cmd_imm_en,
    input  logic [7:0] cmd_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [2:0] rsp_rd,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       rsp_err,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_DIV = 4'b0011;

    logic [1:0] state;
    logic [7:0] rf [0:7];
    logic [2:0] rd_q;
    logic       div_zero_q;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] wb_value;
    logic       cmd_fire;
    logic       rsp_fire;

    // A divide by zero yields all-ones regardless of what the ALU produced.
    function automatic logic [7:0] result_sel(input logic dz, input logic [7:0] res);
        return dz ? 8'hFF : res;
    endfunction

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign wb_value  = result_sel(div_zero_q, alu_out);

    // Operand fetch; register 0 is hardwired to zero on every read port.
    always_comb begin
        op_a     = (cmd_rs1 == 3'd0) ? 8'h00 : rf[cmd_rs1];
        op_b     = cmd_imm_en ? cmd_imm : ((cmd_rs2 == 3'd0) ? 8'h00 : rf[cmd_rs2]);
        dbg_data = (dbg_addr == 3'd0) ? 8'h00 : rf[dbg_addr];
    end

    // Control FSM: one command in flight, three cycles minimum per command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (cmd_fire) state <= EXEC;
                EXEC:    state <= RESP;
                RESP:    if (rsp_fire) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Issue registers toward the ALU (held until the next accept) and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_sel    <= 4'h0;
            rd_q       <= 3'd0;
            div_zero_q <= 1'b0;
            rsp_data   <= 8'h00;
            rsp_rd     <= 3'd0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (cmd_fire) begin
                alu_a      <= op_a;
                alu_b      <= op_b;
                alu_sel    <= cmd_op;
                rd_q       <= cmd_rd;
                div_zero_q <= (cmd_op == OP_DIV) && (op_b == 8'h00);
            end
            if (state == EXEC) begin
                rsp_data  <= wb_value;
                rsp_rd    <= rd_q;
                rsp_carry <= (alu_sel == OP_ADD) ? alu_carry : 1'b0;
                rsp_zero  <= (wb_value == 8'h00);
                rsp_err   <= div_zero_q;
            end
        end
    end

    // Register file writeback at the end of EXEC; writes to register 0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if ((state == EXEC) && (rd_q != 3'd0)) begin
            rf[rd_q] <= wb_value;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: provides the combinational ALU, drives directed
// and random commands, and compares against a register-file reference model.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [2:0] cmd_rd;
    logic [2:0] cmd_rs1;
    logic [2:0] cmd_rs2;
    logic       cmd_imm_en;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [2:0] rsp_rd;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       rsp_err;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] ref_rf [0:7];
    logic [7:0] exp_a, exp_b, exp_data;
    logic [3:0] exp_op;
    logic [2:0] exp_rd;
    logic       exp_carry, exp_zero, exp_err;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_err(rsp_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Behaviour of the 8-bit ALU for each opcode.
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ai = a;
        int bi = b;
        case (op)
            4'h0: return 8'((ai + bi) % 256);
            4'h1: return 8'((ai - bi + 256) % 256);
            4'h2: return 8'((ai * bi) % 256);
            4'h3: return (bi == 0) ? 8'h00 : 8'(ai / bi);
            4'h4: return 8'((ai * 2) % 256);
            4'h5: return 8'(ai / 2);
            4'h6: return 8'(((ai * 2) % 256) + (ai / 128));
            4'h7: return 8'((ai / 2) + ((ai % 2) * 128));
            4'h8: return a & b;
            4'h9: return a | b;
            4'hA: return a ^ b;
            4'hB: return ~(a | b);
            4'hC: return ~(a & b);
            4'hD: return ~(a ^ b);
            4'hE: return (ai > bi) ? 8'h01 : 8'h00;
            default: return (ai == bi) ? 8'h01 : 8'h00;
        endcase
    endfunction

    // Environment ALU feeding the DUT.
    always_comb begin
        alu_out   = alu_fn(alu_sel, alu_a, alu_b);
        alu_carry = ((32'(alu_a) + 32'(alu_b)) > 255);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag);
        chk({tag, "_valid"}, 16'(rsp_valid), 16'd1);
        chk({tag, "_data"},  16'(rsp_data),  16'(exp_data));
        chk({tag, "_rd"},    16'(rsp_rd),    16'(exp_rd));
        chk({tag, "_carry"}, 16'(rsp_carry), 16'(exp_carry));
        chk({tag, "_zero"},  16'(rsp_zero),  16'(exp_zero));
        chk({tag, "_err"},   16'(rsp_err),   16'(exp_err));
    endtask

    // Present a command, wait for acceptance, follow it to the response. Called at a negedge.
    task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic ie, input logic [7:0] imm);
        int n = 0;
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_imm_en = ie; cmd_imm = imm; cmd_valid = 1'b1;
        exp_op    = op;
        exp_rd    = rd;
        exp_a     = ref_rf[rs1];
        exp_b     = ie ? imm : ref_rf[rs2];
        exp_err   = (op == 4'h3) && (exp_b == 8'h00);
        exp_data  = exp_err ? 8'hFF : alu_fn(op, exp_a, exp_b);
        exp_carry = (op == 4'h0) ? ((int'(exp_a) + int'(exp_b)) > 255) : 1'b0;
        exp_zero  = (exp_data == 8'h00);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 16'(cmd_ready), 16'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("exec_no_valid", 16'(rsp_valid), 16'd0);
        chk("exec_ready", 16'(cmd_ready), 16'd0);
        chk("alu_a", 16'(alu_a), 16'(exp_a));
        chk("alu_b", 16'(alu_b), 16'(exp_b));
        chk("alu_sel", 16'(alu_sel), 16'(exp_op));
        @(negedge clk);
        check_rsp("rsp");
    endtask

    // Hold backpressure for 'hold' cycles, then take the response. Ends at a negedge.
    task automatic finish_rsp(input int hold);
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            check_rsp("hold");
            chk("hold_cmd_ready", 16'(cmd_ready), 16'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        if (exp_rd != 3'd0) ref_rf[exp_rd] = exp_data;
        @(negedge clk);
        chk("post_cmd_ready", 16'(cmd_ready), 16'd1);
        chk("post_rsp_valid", 16'(rsp_valid), 16'd0);
        chk("alu_sel_held", 16'(alu_sel), 16'(exp_op));
        dbg_addr = exp_rd;
        #1 chk("dbg_wb", 16'(dbg_data), 16'(ref_rf[exp_rd]));
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1 chk(tag, 16'(dbg_data), 16'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = 4'h0; cmd_rd = 3'd0; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0;
        cmd_imm_en = 1'b0; cmd_imm = 8'h00; dbg_addr = 3'd0;
        #12;
        chk("rst_cmd_ready", 16'(cmd_ready), 16'd1);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        chk("rst_alu_a", 16'(alu_a), 16'd0);
        check_all_zero("rst_dbg");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD with carry
        send(4'h0, 3'd1, 3'd0, 3'd0, 1'b1, 8'hF0); finish_rsp(0);
        send(4'h0, 3'd2, 3'd0, 3'd0, 1'b1, 8'h20); finish_rsp(0);
        send(4'h0, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00);
        chk("add_data", 16'(rsp_data), 16'h10);
        chk("add_carry", 16'(rsp_carry), 16'd1);
        chk("add_zero", 16'(rsp_zero), 16'd0);
        finish_rsp(0);
        chk("add_rf3", 16'(dbg_data), 16'h10);

        // divide by zero and normal divide
        send(4'h3, 3'd6, 3'd1, 3'd0, 1'b1, 8'h00);
        chk("div0_data", 16'(rsp_data), 16'hFF);
        chk("div0_err", 16'(rsp_err), 16'd1);
        finish_rsp(0);
        chk("div0_rf", 16'(dbg_data), 16'hFF);
        send(4'h3, 3'd7, 3'd1, 3'd0, 1'b1, 8'h10);
        chk("div_data", 16'(rsp_data), 16'h0F);
        chk("div_err", 16'(rsp_err), 16'd0);
        finish_rsp(0);

        // XOR to zero, backpressure with a pending EQ command
        send(4'hA, 3'd4, 3'd4, 3'd4, 1'b0, 8'h00);
        chk("xor_zero", 16'(rsp_zero), 16'd1);
        cmd_op = 4'hF; cmd_rd = 3'd0; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0;
        cmd_imm_en = 1'b0; cmd_valid = 1'b1;
        finish_rsp(5);
        send(4'hF, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
        chk("eq_data", 16'(rsp_data), 16'h01);
        chk("eq_zero", 16'(rsp_zero), 16'd0);
        finish_rsp(0);
        chk("eq_r0", 16'(dbg_data), 16'h00);

        // back-to-back dependency, shift and rotate
        send(4'h0, 3'd5, 3'd0, 3'd0, 1'b1, 8'h07); finish_rsp(0);
        send(4'h4, 3'd5, 3'd5, 3'd0, 1'b0, 8'h00);
        chk("shl_data", 16'(rsp_data), 16'h0E);
        finish_rsp(0);
        send(4'h0, 3'd2, 3'd0, 3'd0, 1'b1, 8'h81); finish_rsp(1);
        send(4'h6, 3'd2, 3'd2, 3'd0, 1'b0, 8'h00);
        chk("rotl_data", 16'(rsp_data), 16'h03);
        finish_rsp(0);

        // reset while a response is pending
        send(4'h1, 3'd3, 3'd5, 3'd1, 1'b0, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 16'(rsp_valid), 16'd0);
        chk("mid_rst_cmd_ready", 16'(cmd_ready), 16'd1);
        chk("mid_rst_rsp_data", 16'(rsp_data), 16'd0);
        chk("mid_rst_alu_sel", 16'(alu_sel), 16'd0);
        check_all_zero("mid_rst_dbg");
        for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // random commands
        for (int k = 0; k < 40; k++) begin
            logic [7:0] imm;
            imm = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            send(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), imm);
            finish_rsp(int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
